inst_fetch_ctrl: RTL and testbench

- Responder side of the instruction-fetch handshake that the IF stage consumes.
- Accepts a PC request and reads four bytes from the byte-wide unified memory port.
- Assembles them little-endian into a 32-bit instruction and returns it with a one-cycle inst_enable_o strobe.
- While it is not strobing, IF holds its lock asserted.

---
 rtl/inst_fetch_ctrl_pkg.sv | 19 +
 rtl/inst_fetch_ctrl_icache_dm.sv | 57 +++++
 rtl/inst_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, constants and fetch-state encoding for the instruction-fetch responder.
package inst_fetch_ctrl_pkg;

  localparam int unsigned INST_ADDR_W = 32;  // default PC / memory address width
  localparam int unsigned INST_W      = 32;  // assembled instruction width
  localparam int unsigned BYTE_W      = 8;   // memory port data width
  localparam int unsigned INST_BYTES  = 4;   // bytes per instruction
  localparam int unsigned CNT_W       = 3;   // counts 0..INST_BYTES
  localparam int unsigned BIDX_W      = 2;   // byte lane within a word

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DONE  = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache (lookup + fill port).
// Only compiled when ICACHE_EN is defined; the default build has no cache storage.
`ifdef ICACHE_EN
module icache_dm
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W,
  parameter int unsigned LINES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_c_o,
  output logic [INST_W-1:0] rdata_c_o,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_pc_i,
  input  logic [INST_W-1:0] fill_data_i
);

  localparam int unsigned LINE_W = $clog2(LINES);
  // Byte offset is kept with the tag so an unaligned PC never aliases an aligned one.
  localparam int unsigned TAG_W  = ADDR_W - LINE_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  logic [LINE_W-1:0] lk_idx, fl_idx;
  logic [TAG_W-1:0]  lk_tag, fl_tag;

  assign lk_idx = lookup_pc_i[LINE_W+BIDX_W-1:BIDX_W];
  assign fl_idx = fill_pc_i[LINE_W+BIDX_W-1:BIDX_W];
  assign lk_tag = {lookup_pc_i[ADDR_W-1:LINE_W+BIDX_W], lookup_pc_i[BIDX_W-1:0]};
  assign fl_tag = {fill_pc_i[ADDR_W-1:LINE_W+BIDX_W], fill_pc_i[BIDX_W-1:0]};

  assign hit_c_o   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign rdata_c_o = data_q[lk_idx];

  // Valid bits: cleared by reset only, set on fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[fl_idx] <= 1'b1;
    end
  end

  // Tag and data storage: written on fill, no reset needed behind the valid bits.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[fl_idx]  <= fl_tag;
      data_q[fl_idx] <= fill_data_i;
    end
  end

endmodule
`endif

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch responder: reads four bytes from the byte-wide memory port,
// assembles them little-endian and returns them with a one-cycle inst_enable_o.
// Optional feature: define ICACHE_EN to place icache_dm in front of the fetch path.
// mem_rd_o/mem_a_o/inst_enable_o are combinational: the arbiter grant and the
// redirect act in the same cycle.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W
`ifdef ICACHE_EN
  ,
  parameter int unsigned ICACHE_LINES = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  input  logic [BYTE_W-1:0] mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_rd_o,
  output logic              inst_enable_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_pc_q, base_pc_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic              pend_q, pend_d;
  logic [BIDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              issue;
  logic              start;
  logic              hit_wait;

`ifdef ICACHE_EN
  logic              hit_pend_q, hit_pend_d;
  logic              lookup_hit;
  logic [INST_W-1:0] lookup_data;
  logic              fill_en;

  icache_dm #(
    .ADDR_W (ADDR_W),
    .LINES  (ICACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc_i (pc_i),
    .hit_c_o     (lookup_hit),
    .rdata_c_o   (lookup_data),
    .fill_i      (fill_en),
    .fill_pc_i   (base_pc_q),
    .fill_data_i (buf_d)
  );

  // A hit spends one FETCH cycle with reads suppressed before DONE.
  assign hit_wait = hit_pend_q;
`else
  assign hit_wait = 1'b0;
`endif

  // A new fetch begins from IDLE, or from any state when redirected with a request.
  assign start = fetch_req_i && ((state_q == IF_IDLE) || flush_i);

  // Next-state, issue and byte-assembly logic.
  always_comb begin
    state_d     = state_q;
    base_pc_d   = base_pc_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pend_d      = 1'b0;
    pend_idx_d  = pend_idx_q;
    buf_d       = buf_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    issue       = 1'b0;
`ifdef ICACHE_EN
    hit_pend_d  = 1'b0;
    fill_en     = 1'b0;
`endif

    unique case (state_q)
      IF_FETCH: begin
        if (hit_wait) begin
          state_d = IF_DONE;
        end else begin
          if ((issue_cnt_q < CNT_W'(INST_BYTES)) && !mem_busy_i) begin
            issue       = 1'b1;
            pend_d      = 1'b1;
            pend_idx_d  = issue_cnt_q[BIDX_W-1:0];
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
          end
          if (pend_q) begin
            for (int unsigned k = 0; k < INST_BYTES; k++) begin
              if (pend_idx_q == BIDX_W'(k)) begin
                buf_d[k*BYTE_W +: BYTE_W] = mem_din_i;
              end
            end
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
            if (cap_cnt_d == CNT_W'(INST_BYTES)) begin
              state_d = IF_DONE;
            end
          end
        end
      end
      IF_DONE: state_d = IF_IDLE;
      default: state_d = state_q;
    endcase

    // Redirect aborts the fetch, drops the in-flight byte and this cycle's read.
    if (flush_i) begin
      state_d = IF_IDLE;
      pend_d  = 1'b0;
      issue   = 1'b0;
    end

    if (start) begin
      state_d     = IF_FETCH;
      base_pc_d   = pc_i;
      issue_cnt_d = '0;
      cap_cnt_d   = '0;
      pend_d      = 1'b0;
`ifdef ICACHE_EN
      if (lookup_hit) begin
        hit_pend_d = 1'b1;
        buf_d      = lookup_data;
      end
`endif
    end

    // Result registers load on entry to DONE and hold until the next one.
    if (state_d == IF_DONE) begin
      inst_d    = buf_d;
      inst_pc_d = base_pc_d;
`ifdef ICACHE_EN
      fill_en   = !hit_wait;
`endif
    end
  end

  assign mem_rd_o      = issue;
  assign mem_a_o       = issue ? (base_pc_q + ADDR_W'(issue_cnt_q)) : '0;
  assign inst_enable_o = (state_q == IF_DONE) && !flush_i;
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;

  // State register; reset discards any partially assembled word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IF_IDLE;
      base_pc_q   <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      buf_q       <= ZERO_WORD;
      inst_q      <= ZERO_WORD;
      inst_pc_q   <= '0;
`ifdef ICACHE_EN
      hit_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_pc_q   <= base_pc_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      buf_q       <= buf_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
`ifdef ICACHE_EN
      hit_pend_q  <= hit_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: expected reads and pulses are queued
// when a request is driven and checked by a negedge monitor as the DUT produces them.
module tb_inst_fetch_ctrl;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req_i = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic          flush_i = 1'b0;
  logic          mem_busy_i = 1'b0;
  logic [7:0]    mem_din_i = 8'hEE;
  logic [AW-1:0] mem_a_o;
  logic          mem_rd_o;
  logic          inst_enable_o;
  logic [31:0]   inst_o;
  logic [AW-1:0] inst_pc_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { logic [31:0] addr; int cyc; } rd_exp_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; int cyc; } pulse_exp_t;

  rd_exp_t    rd_q[$];
  pulse_exp_t pulse_q[$];

  inst_fetch_ctrl #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req_i   (fetch_req_i),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .mem_busy_i    (mem_busy_i),
    .mem_din_i     (mem_din_i),
    .mem_a_o       (mem_a_o),
    .mem_rd_o      (mem_rd_o),
    .inst_enable_o (inst_enable_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h05;
      32'h0000_0002: return 8'h10;
      32'h0000_0003: return 8'h00;
      32'h0000_0100: return 8'h37;
      32'h0000_0101: return 8'h01;
      32'h0000_0102: return 8'h00;
      32'h0000_0103: return 8'hFE;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Memory model: data returns one cycle after the address is issued.
  always @(posedge clk) mem_din_i <= mem_rd_o ? mem_byte(mem_a_o) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: every read and every pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mem_rd_o) begin
      if (rd_q.size() == 0) begin
        chk("spurious_read", 32'(mem_rd_o), 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_addr", mem_a_o, e.addr);
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk("idle_addr", mem_a_o, 32'd0);
    end
    if (inst_enable_o) begin
      if (pulse_q.size() == 0) begin
        chk("spurious_pulse", 32'(inst_enable_o), 32'd0);
      end else begin
        pulse_exp_t p;
        p = pulse_q.pop_front();
        chk("pulse_inst", inst_o, p.inst);
        chk("pulse_pc", inst_pc_o, p.pc);
        chk("pulse_cycle", 32'(cyc), 32'(p.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [31:0] a, input int c);
    rd_exp_t e;
    e.addr = a;
    e.cyc  = c;
    rd_q.push_back(e);
  endtask

  task automatic push_pulse(input logic [31:0] inst, input logic [31:0] pc, input int c);
    pulse_exp_t p;
    p.inst = inst;
    p.pc   = pc;
    p.cyc  = c;
    pulse_q.push_back(p);
  endtask

  // Uninterrupted fetch whose request is sampled in cycle n.
  task automatic push_fetch(input logic [31:0] pc, input logic [31:0] inst, input int n);
    for (int k = 0; k < 4; k++) push_rd(pc + 32'(k), n + 1 + k);
    push_pulse(inst, pc, n + 6);
  endtask

  task automatic begin_req(input logic [31:0] pc, output int n);
    tick();
    n = cyc;
    fetch_req_i = 1'b1;
    pc_i = pc;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    while (((rd_q.size() != 0) || (pulse_q.size() != 0)) && (budget > 0)) begin
      tick();
      budget--;
    end
    chk({tag, "_drained"}, 32'(rd_q.size() + pulse_q.size()), 32'd0);
    rd_q.delete();
    pulse_q.delete();
    repeat (3) tick();
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;

    // Reset state
    repeat (2) tick();
    chk("rst_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_addr", mem_a_o, 32'd0);
    chk("rst_en", 32'(inst_enable_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", inst_pc_o, 32'd0);
    rst = 1'b1;
    tick();

    // Basic fetch at 0x0
    begin_req(32'h0, n);
    push_fetch(32'h0, 32'h0010_0513, n);
    tick();
    fetch_req_i = 1'b0;
    drain("basic");
    chk("basic_hold_inst", inst_o, 32'h0010_0513);
    chk("basic_hold_pc", inst_pc_o, 32'h0);

    // Arbitration stall during the second issue cycle
    reset_dut();
    begin_req(32'h0, n);
    push_rd(32'h0, n + 1);
    push_rd(32'h1, n + 3);
    push_rd(32'h2, n + 4);
    push_rd(32'h3, n + 5);
    push_pulse(32'h0010_0513, 32'h0, n + 7);
    tick();
    fetch_req_i = 1'b0;
    tick();
    mem_busy_i = 1'b1;
    tick();
    mem_busy_i = 1'b0;
    drain("stall");

    // Flush after two bytes with a new request to 0x100
    reset_dut();
    begin_req(32'h0, n);
    push_rd(32'h0, n + 1);
    push_rd(32'h1, n + 2);
    tick();
    fetch_req_i = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    fetch_req_i = 1'b1;
    pc_i = 32'h100;
    push_fetch(32'h100, 32'hFE00_0137, n + 3);
    tick();
    flush_i = 1'b0;
    fetch_req_i = 1'b0;
    drain("flush");

    // Address wrap-around
    reset_dut();
    begin_req(32'hFFFF_FFFE, n);
    push_fetch(32'hFFFF_FFFE, 32'h0513_BBAA, n);
    tick();
    fetch_req_i = 1'b0;
    drain("wrap");

    // Flush in DONE suppresses the pulse
    reset_dut();
    begin_req(32'h0, n);
    for (int k = 0; k < 4; k++) push_rd(32'(k), n + 1 + k);
    tick();
    fetch_req_i = 1'b0;
    repeat (5) tick();
    flush_i = 1'b1;
    #1;
    chk("done_flush_en", 32'(inst_enable_o), 32'd0);
    tick();
    flush_i = 1'b0;
    drain("done_flush");

    // mem_busy_i stuck high stalls with no timeout
    reset_dut();
    begin_req(32'h100, n);
    tick();
    fetch_req_i = 1'b0;
    mem_busy_i = 1'b1;
    repeat (20) tick();
    mem_busy_i = 1'b0;
    m = cyc;
    push_fetch(32'h100, 32'hFE00_0137, m - 1);
    drain("busy_hold");

    // Reset mid-fetch after two issues
    begin_req(32'h0, n);
    push_rd(32'h0, n + 1);
    push_rd(32'h1, n + 2);
    tick();
    fetch_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_rd", 32'(mem_rd_o), 32'd0);
    chk("midrst_addr", mem_a_o, 32'd0);
    chk("midrst_en", 32'(inst_enable_o), 32'd0);
    chk("midrst_inst", inst_o, 32'd0);
    chk("midrst_pc", inst_pc_o, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    drain("midrst");

    // Same PC fetched twice: second is a cache hit when the cache is built in
    reset_dut();
    begin_req(32'h0, n);
    push_fetch(32'h0, 32'h0010_0513, n);
    tick();
    fetch_req_i = 1'b0;
    drain("refetch_first");
    begin_req(32'h0, n);
`ifdef ICACHE_EN
    push_pulse(32'h0010_0513, 32'h0, n + 2);
`else
    push_fetch(32'h0, 32'h0010_0513, n);
`endif
    tick();
    fetch_req_i = 1'b0;
    drain("refetch_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
